fmul_arbiter: RTL and testbench

Two-requester controller that shares one 10-bit floating-point multiplier (sign bit 9, 5-bit mantissa [8:4], 4-bit two's-complement exponent [3:0]) between two clients. It arbitrates round-robin and drives the multiplier's load/start/done sequence. It captures the result and overflow/underflow flags and returns them to the winning requester with a one-cycle response pulse. It sits between the multiplier and the two datapath clients that issue multiply operations.

---
 rtl/fmul_arb_pkg.sv | 32 +++
 rtl/fmul_arbiter_if.sv | 51 +++++
 rtl/fmul_rr_arb.sv | 28 ++
 rtl/fmul_arbiter.sv | 155 +++++++++++++++
 tb/tb_fmul_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmul_arb_pkg.sv
// ============================================================================
// Module      : fmul_arb_pkg
// Description : Shared types and constants for the two-client fp multiplier
//               arbiter (10-bit format: sign[9], mantissa[8:4], exp[3:0]).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fmul_arb_pkg;

    localparam int W         = 10;
    localparam int SIGN_BIT  = 9;
    localparam int MANT_MSB  = 8;
    localparam int MANT_LSB  = 4;
    localparam int EXP_MSB   = 3;

    // Canonical zero: mantissa 0 with the most negative exponent.
    localparam logic [W-1:0] ZERO_RESULT = 10'b0000001000;

    localparam int TIMEOUT_CYC_DFLT = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage : fmul_arb_pkg

`default_nettype wire

// File: rtl/fmul_arbiter_if.sv
// ============================================================================
// Module      : fmul_arbiter_if
// Description : Client request/response and multiplier control bundle.
//               master = arbiter view, slave = clients + multiplier view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fmul_arbiter_if;
    import fmul_arb_pkg::*;

    logic         req0;
    logic         req1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         rsp_valid0;
    logic         rsp_valid1;
    logic [W-1:0] rsp_f;
    logic         rsp_ovf;
    logic         rsp_udf;
    logic         rsp_err;
    logic         busy;

    logic         mul_load;
    logic         mul_start;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic         mul_done;
    logic [W-1:0] mul_f;
    logic         mul_ovf;
    logic         mul_udf;

    modport master (
        input  req0, req1, a0, b0, a1, b1,
        output rsp_valid0, rsp_valid1, rsp_f, rsp_ovf, rsp_udf, rsp_err, busy,
        output mul_load, mul_start, mul_a, mul_b,
        input  mul_done, mul_f, mul_ovf, mul_udf
    );

    modport slave (
        output req0, req1, a0, b0, a1, b1,
        input  rsp_valid0, rsp_valid1, rsp_f, rsp_ovf, rsp_udf, rsp_err, busy,
        input  mul_load, mul_start, mul_a, mul_b,
        output mul_done, mul_f, mul_ovf, mul_udf
    );

endinterface : fmul_arbiter_if

`default_nettype wire

// File: rtl/fmul_rr_arb.sv
// ============================================================================
// Module      : fmul_rr_arb
// Description : Combinational 2-way round-robin picker; i_ptr names the
//               client favoured when both request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmul_rr_arb (
    input  wire logic i_req0,
    input  wire logic i_req1,
    input  wire logic i_ptr,
    output logic      o_gnt_id,
    output logic      o_gnt_valid
);

    always_comb begin
        o_gnt_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_gnt_id = i_ptr;
        end else begin
            o_gnt_id = i_req1;
        end
    end

endmodule : fmul_rr_arb

`default_nettype wire

// File: rtl/fmul_arbiter.sv
// ============================================================================
// Module      : fmul_arbiter
// Description : Shares one fp multiplier between two clients (round-robin),
//               sequencing load/start/done. Optional FMUL_ARB_TIMEOUT_EN
//               aborts WAIT after TIMEOUT_CYC cycles with rsp_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmul_arbiter
    import fmul_arb_pkg::*;
`ifdef FMUL_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
)
`endif
(
    input  wire logic      clk,
    input  wire logic      rstn,
    fmul_arbiter_if.master bus
);

    state_t       r_state;
    logic         r_ptr;
    logic         r_gnt;
    logic [W-1:0] r_mul_a;
    logic [W-1:0] r_mul_b;
    logic         r_mul_load;
    logic         r_mul_start;
    logic [W-1:0] r_rsp_f;
    logic         r_rsp_ovf;
    logic         r_rsp_udf;
    logic         r_rsp_valid0;
    logic         r_rsp_valid1;
    logic         r_busy;
    logic         w_gnt_id;
    logic         w_gnt_valid;

`ifdef FMUL_ARB_TIMEOUT_EN
    localparam logic [3:0] c_TIMEOUT = 4'(TIMEOUT_CYC);
    logic [3:0]   r_wait_cnt;
    logic         r_rsp_err;
`endif

    fmul_rr_arb u_pick (
        .i_req0      (bus.req0),
        .i_req1      (bus.req1),
        .i_ptr       (r_ptr),
        .o_gnt_id    (w_gnt_id),
        .o_gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b0;
            r_gnt        <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_load   <= 1'b0;
            r_mul_start  <= 1'b0;
            r_rsp_f      <= '0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_udf    <= 1'b0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_busy       <= 1'b0;
`ifdef FMUL_ARB_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt      <= w_gnt_id;
                        r_mul_a    <= w_gnt_id ? bus.a1 : bus.a0;
                        r_mul_b    <= w_gnt_id ? bus.b1 : bus.b0;
                        r_mul_load <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_mul_load  <= 1'b0;
                    r_mul_start <= 1'b1;
                    r_state     <= ST_START;
                end
                ST_START: begin
                    r_mul_start <= 1'b0;
`ifdef FMUL_ARB_TIMEOUT_EN
                    r_wait_cnt  <= '0;
`endif
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the expiry cycle still delivers its result.
                    if (bus.mul_done) begin
                        r_rsp_f      <= bus.mul_f;
                        r_rsp_ovf    <= bus.mul_ovf;
                        r_rsp_udf    <= bus.mul_udf;
`ifdef FMUL_ARB_TIMEOUT_EN
                        r_rsp_err    <= 1'b0;
`endif
                        r_rsp_valid0 <= ~r_gnt;
                        r_rsp_valid1 <= r_gnt;
                        r_state      <= ST_RESP;
                    end
`ifdef FMUL_ARB_TIMEOUT_EN
                    else if (r_wait_cnt == c_TIMEOUT) begin
                        r_rsp_f      <= '0;
                        r_rsp_ovf    <= 1'b0;
                        r_rsp_udf    <= 1'b0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid0 <= ~r_gnt;
                        r_rsp_valid1 <= r_gnt;
                        r_state      <= ST_RESP;
                    end else begin
                        r_wait_cnt   <= r_wait_cnt + 4'd1;
                    end
`endif
                end
                ST_RESP: begin
                    r_rsp_valid0 <= 1'b0;
                    r_rsp_valid1 <= 1'b0;
                    r_ptr        <= ~r_gnt;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid0 = r_rsp_valid0;
    assign bus.rsp_valid1 = r_rsp_valid1;
    assign bus.rsp_f      = r_rsp_f;
    assign bus.rsp_ovf    = r_rsp_ovf;
    assign bus.rsp_udf    = r_rsp_udf;
    assign bus.busy       = r_busy;
    assign bus.mul_load   = r_mul_load;
    assign bus.mul_start  = r_mul_start;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
`ifdef FMUL_ARB_TIMEOUT_EN
    assign bus.rsp_err    = r_rsp_err;
`else
    assign bus.rsp_err    = 1'b0;
`endif

endmodule : fmul_arbiter

`default_nettype wire

// File: tb/tb_fmul_arbiter.sv
// ============================================================================
// Module      : tb_fmul_arbiter
// Description : Self-checking bench for fmul_arbiter with a behavioural
//               multiplier stub and a round-robin/result reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmul_arbiter;
    import fmul_arb_pkg::*;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    fmul_arbiter_if bus ();

    fmul_arbiter u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply: returns {ovf, udf, f}.
    function automatic logic [11:0] fmul_model(input logic [9:0] a, input logic [9:0] b);
        logic s;
        int   ma, mb, ea, eb, p, e, m;
        logic [3:0] ebits;
        logic [4:0] mbits;
        s  = a[9] ^ b[9];
        ma = int'(a[8:4]);
        mb = int'(b[8:4]);
        ea = int'($signed(a[3:0]));
        eb = int'($signed(b[3:0]));
        if (ma == 0 || mb == 0) return {2'b00, 10'b0000001000};
        p = ma * mb;
        e = ea + eb;
        if (p >= 512) m = p / 32;
        else begin
            m = (p / 16) % 32;
            e = e - 1;
        end
        if (e > 7)  return {2'b10, s, 5'h1F, 4'h7};
        if (e < -8) return {2'b01, 10'b0000001000};
        ebits = e[3:0];
        mbits = m[4:0];
        return {2'b00, s, mbits, ebits};
    endfunction

    // Multiplier stub: done pulses k_lat cycles after the start cycle.
    int         k_lat = 3;
    bit         stub_never = 1'b0;
    bit         stray = 1'b0;
    logic [9:0] stray_f = '0;
    logic [4:0] stub_cnt;
    logic [11:0] stub_res;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stub_cnt     <= '0;
            bus.mul_done <= 1'b0;
            bus.mul_f    <= '0;
            bus.mul_ovf  <= 1'b0;
            bus.mul_udf  <= 1'b0;
        end else begin
            bus.mul_done <= 1'b0;
            bus.mul_f    <= 10'($urandom);
            bus.mul_ovf  <= 1'($urandom);
            bus.mul_udf  <= 1'($urandom);
            if (stray) begin
                bus.mul_done <= 1'b1;
                bus.mul_f    <= stray_f;
            end else if (bus.mul_start && !stub_never) begin
                stub_cnt <= 5'(k_lat - 1);
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 5'd1;
                if (stub_cnt == 5'd1) begin
                    stub_res = fmul_model(bus.mul_a, bus.mul_b);
                    bus.mul_done <= 1'b1;
                    bus.mul_f    <= stub_res[9:0];
                    bus.mul_ovf  <= stub_res[11];
                    bus.mul_udf  <= stub_res[10];
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        stray = 1'b0;
        stub_never = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Counts negedges from now until a response pulse; who=-1 on timeout, 2 if both.
    task automatic wait_rsp(input int limit, output int cyc, output int who);
        cyc = 0;
        who = -1;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid0 || bus.rsp_valid1) begin
                who = (bus.rsp_valid0 && bus.rsp_valid1) ? 2 : (bus.rsp_valid1 ? 1 : 0);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.rsp_valid0, bus.rsp_valid1, bus.busy, bus.mul_load, bus.mul_start} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000",
                {bus.rsp_valid0, bus.rsp_valid1, bus.busy, bus.mul_load, bus.mul_start});
        end
        checks++;
        if ({bus.rsp_f, bus.rsp_ovf, bus.rsp_udf, bus.rsp_err, bus.mul_a, bus.mul_b} !== 33'b0) begin
            errors++; $display("FAIL reset_data got f=%h a=%h b=%h want 0", bus.rsp_f, bus.mul_a, bus.mul_b);
        end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        int cyc, who;
        bit saw1;
        @(negedge clk);
        bus.a0 = {1'($urandom), 5'b00000, 4'($urandom)};
        bus.b0 = 10'($urandom);
        k_lat = 3;
        bus.req0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mul_load, bus.mul_start, bus.busy} !== 3'b101 || bus.mul_a !== bus.a0) begin
            errors++; $display("FAIL single_cyc1 got ld/st/busy=%b mul_a=%h want 101 %h",
                {bus.mul_load, bus.mul_start, bus.busy}, bus.mul_a, bus.a0);
        end
        @(negedge clk);
        checks++;
        if ({bus.mul_load, bus.mul_start} !== 2'b01) begin
            errors++; $display("FAIL single_cyc2 got ld/st=%b want 01", {bus.mul_load, bus.mul_start});
        end
        wait_rsp(30, cyc, who);
        cyc += 2;
        checks++;
        if (who !== 0 || cyc !== 6) begin
            errors++; $display("FAIL single_rsp got who=%0d cyc=%0d want 0 6", who, cyc);
        end
        checks++;
        if (bus.rsp_f !== ZERO_RESULT || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_zero got %b want %b", bus.rsp_f, ZERO_RESULT);
        end
        bus.req0 = 1'b0;
        saw1 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid0 !== 1'b0 || bus.rsp_f !== ZERO_RESULT) begin
            errors++; $display("FAIL single_pulse got v0=%b f=%b want 0 %b", bus.rsp_valid0, bus.rsp_f, ZERO_RESULT);
        end
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid0 || bus.rsp_valid1) saw1 = 1'b1;
        end
        checks++;
        if (saw1 !== 1'b0) begin
            errors++; $display("FAIL single_extra got extra response want none");
        end
    endtask

    task automatic test_round_robin();
        int cyc, who;
        logic [11:0] exp_r;
        do_reset();
        k_lat = 3;
        bus.a0 = 10'($urandom); bus.b0 = 10'($urandom);
        bus.a1 = 10'($urandom); bus.b1 = 10'($urandom);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(30, cyc, who);
            exp_r = (i % 2 == 0) ? fmul_model(bus.a0, bus.b0) : fmul_model(bus.a1, bus.b1);
            checks++;
            if (who !== (i % 2) || cyc !== ((i == 0) ? 6 : 7)) begin
                errors++; $display("FAIL rr_order[%0d] got who=%0d cyc=%0d want %0d %0d",
                    i, who, cyc, i % 2, (i == 0) ? 6 : 7);
            end
            checks++;
            if ({bus.rsp_ovf, bus.rsp_udf, bus.rsp_f} !== exp_r) begin
                errors++; $display("FAIL rr_data[%0d] got %h want %h", i,
                    {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f}, exp_r);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flags();
        int cyc, who;
        logic [11:0] exp_r;
        bus.a0 = {1'b0, 5'b10110, 4'b0111};
        bus.b0 = {1'b1, 5'b11001, 4'b0111};
        exp_r = fmul_model(bus.a0, bus.b0);
        bus.req0 = 1'b1;
        wait_rsp(30, cyc, who);
        bus.req0 = 1'b0;
        checks++;
        if (who !== 0 || bus.rsp_ovf !== 1'b1 || {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f} !== exp_r) begin
            errors++; $display("FAIL flags_ovf got who=%0d %h want 0 %h", who,
                {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f}, exp_r);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.rsp_ovf !== 1'b1 || bus.rsp_f !== exp_r[9:0]) begin
            errors++; $display("FAIL flags_hold got ovf=%b f=%h want 1 %h", bus.rsp_ovf, bus.rsp_f, exp_r[9:0]);
        end
        bus.a1 = {1'b0, 5'b10000, 4'b1000};
        bus.b1 = {1'b0, 5'b10000, 4'b1000};
        exp_r = fmul_model(bus.a1, bus.b1);
        bus.req1 = 1'b1;
        wait_rsp(30, cyc, who);
        bus.req1 = 1'b0;
        checks++;
        if (who !== 1 || {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f} !== exp_r || exp_r[10] !== 1'b1) begin
            errors++; $display("FAIL flags_udf got who=%0d %h want 1 %h", who,
                {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f}, exp_r);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, who;
        bit saw;
        logic [11:0] exp_r;
        bus.a0 = {1'b0, 5'b11111, 4'b0001};
        bus.b0 = {1'b0, 5'b11111, 4'b0001};
        k_lat = 3;
        bus.req0 = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        bus.req0 = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.mul_load, bus.mul_start, bus.rsp_valid0, bus.rsp_valid1} !== 5'b0 ||
            {bus.rsp_f, bus.rsp_ovf, bus.rsp_udf, bus.mul_a, bus.mul_b} !== 32'b0) begin
            errors++; $display("FAIL rst_mid got busy=%b f=%h a=%h want 0 0 0", bus.busy, bus.rsp_f, bus.mul_a);
        end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid0 || bus.rsp_valid1 || bus.busy) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++; $display("FAIL rst_drop got activity after reset want none");
        end
        bus.a1 = 10'($urandom); bus.b1 = 10'($urandom);
        exp_r = fmul_model(bus.a1, bus.b1);
        bus.req1 = 1'b1;
        wait_rsp(30, cyc, who);
        bus.req1 = 1'b0;
        checks++;
        if (who !== 1 || cyc !== 6 || {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f} !== exp_r) begin
            errors++; $display("FAIL rst_next got who=%0d cyc=%0d %h want 1 6 %h", who, cyc,
                {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f}, exp_r);
        end
        @(negedge clk);
    endtask

    task automatic test_stray();
        logic [9:0] held;
        bit saw;
        held = bus.rsp_f;
        stray_f = ~held;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid0 || bus.rsp_valid1 || bus.busy) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || bus.rsp_f !== held) begin
            errors++; $display("FAIL stray_done got saw=%b f=%h want 0 %h", saw, bus.rsp_f, held);
        end
    endtask

    task automatic test_long_wait();
        int cyc, who;
        logic [11:0] exp_r;
        bus.a0 = 10'($urandom); bus.b0 = 10'($urandom);
`ifdef FMUL_ARB_TIMEOUT_EN
        stub_never = 1'b1;
        bus.req0 = 1'b1;
        wait_rsp(40, cyc, who);
        bus.req0 = 1'b0;
        checks++;
        if (who !== 0 || cyc !== 19 || bus.rsp_err !== 1'b1 ||
            {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f} !== 12'b0) begin
            errors++; $display("FAIL timeout got who=%0d cyc=%0d err=%b f=%h want 0 19 1 0",
                who, cyc, bus.rsp_err, bus.rsp_f);
        end
        stub_never = 1'b0;
        @(negedge clk);
`endif
        k_lat = 16;
        exp_r = fmul_model(bus.a0, bus.b0);
        bus.req0 = 1'b1;
        wait_rsp(40, cyc, who);
        bus.req0 = 1'b0;
        checks++;
        if (who !== 0 || cyc !== 19 || bus.rsp_err !== 1'b0 ||
            {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f} !== exp_r) begin
            errors++; $display("FAIL done_at_expiry got who=%0d cyc=%0d err=%b %h want 0 19 0 %h",
                who, cyc, bus.rsp_err, {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f}, exp_r);
        end
        k_lat = 3;
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc, who, pat, winner, favour;
        logic [11:0] exp_r;
        do_reset();
        favour = 0;
        for (int i = 0; i < 24; i++) begin
            k_lat = $urandom_range(2, 6);
            bus.a0 = 10'($urandom); bus.b0 = 10'($urandom);
            bus.a1 = 10'($urandom); bus.b1 = 10'($urandom);
            pat = $urandom_range(1, 3);
            winner = (pat == 3) ? favour : ((pat == 2) ? 1 : 0);
            exp_r = (winner == 1) ? fmul_model(bus.a1, bus.b1) : fmul_model(bus.a0, bus.b0);
            bus.req0 = pat[0];
            bus.req1 = pat[1];
            wait_rsp(30, cyc, who);
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            checks++;
            if (who !== winner || cyc !== 3 + k_lat) begin
                errors++; $display("FAIL rand_grant[%0d] got who=%0d cyc=%0d want %0d %0d",
                    i, who, cyc, winner, 3 + k_lat);
            end
            checks++;
            if ({bus.rsp_ovf, bus.rsp_udf, bus.rsp_f} !== exp_r || bus.rsp_err !== 1'b0) begin
                errors++; $display("FAIL rand_data[%0d] got %h err=%b want %h 0", i,
                    {bus.rsp_ovf, bus.rsp_udf, bus.rsp_f}, bus.rsp_err, exp_r);
            end
            if (who == winner) favour = 1 - winner;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_flags();
        test_reset_mid();
        test_stray();
        test_long_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fmul_arbiter

`default_nettype wire
